// File: rtl/address_offset_writer_if.sv
// address_offset_writer_if
//   Groups the ALU writeback bus and the PO/DO write bus used by
//   address_offset_writer.
//   master : writeback source side (drives write_*, IO_Ready_in, Cancel_in;
//            observes the PO/DO write outputs).
//   slave  : address_offset_writer side.
//   Signals:
//     write_enable, write_addr, write_data, IO_Ready_in, Cancel_in
//       - writeback from the ALU stage plus its instruction qualifiers.
//     po_wren, po_write_addr, po_write_data
//       - PO entry write toward the address module.
//     do_wren, do_write_data
//       - DO write toward the address module.
//     IO_Ready_previous, Cancel_previous
//       - registered qualifiers forwarded to the address module.
//     init_busy, write_dropped
//       - PO clear in progress / writeback discarded during the clear.
interface address_offset_writer_if #(
  parameter int ADDR_WIDTH     = 10,
  parameter int WORD_WIDTH     = 36,
  parameter int PO_ADDR_WIDTH  = 2,
  parameter int PO_ENTRY_WIDTH = 22
);
  logic                      write_enable;
  logic [ADDR_WIDTH-1:0]     write_addr;
  logic [WORD_WIDTH-1:0]     write_data;
  logic                      IO_Ready_in;
  logic                      Cancel_in;
  logic                      po_wren;
  logic [PO_ADDR_WIDTH-1:0]  po_write_addr;
  logic [PO_ENTRY_WIDTH-1:0] po_write_data;
  logic                      do_wren;
  logic [ADDR_WIDTH-1:0]     do_write_data;
  logic                      IO_Ready_previous;
  logic                      Cancel_previous;
  logic                      init_busy;
  logic                      write_dropped;

  modport master (
    output write_enable, write_addr, write_data, IO_Ready_in, Cancel_in,
    input  po_wren, po_write_addr, po_write_data, do_wren, do_write_data,
    input  IO_Ready_previous, Cancel_previous, init_busy, write_dropped
  );

  modport slave (
    input  write_enable, write_addr, write_data, IO_Ready_in, Cancel_in,
    output po_wren, po_write_addr, po_write_data, do_wren, do_write_data,
    output IO_Ready_previous, Cancel_previous, init_busy, write_dropped
  );
endinterface

// File: rtl/address_offset_writer.sv
// address_offset_writer
//   Maps ALU writebacks onto the per-thread programmed-offset (PO) entries
//   and the default-offset (DO) register of the address module. After reset
//   it first clears every PO entry (INIT), holding each entry index for
//   THREAD_COUNT cycles so the downstream rotating thread pointer writes the
//   entry for every thread; then it decodes writebacks forever (RUN).
//   Ports:
//     clock   - single clock, rising edge.
//     reset_n - asynchronous, active-low reset.
//     bus     - address_offset_writer_if.slave: writeback in, PO/DO write
//               out, forwarded qualifiers, init_busy / write_dropped status.
//   All outputs are registered: one cycle from inputs/state to outputs.
module address_offset_writer #(
  parameter int ADDR_WIDTH         = 10,
  parameter int WORD_WIDTH         = 36,
  parameter int PO_ADDR_WIDTH      = 2,
  parameter int PO_ENTRY_COUNT     = 4,
  parameter int PO_ENTRY_WIDTH     = 22,
  parameter int PO_INIT_VALUE      = 0,
  parameter int PO_BASE_ADDR       = 1000,
  parameter int DO_ADDR            = 1004,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  address_offset_writer_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] PO_LO = ADDR_WIDTH'(PO_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PO_HI = ADDR_WIDTH'(PO_BASE_ADDR + PO_ENTRY_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] DO_A  = ADDR_WIDTH'(DO_ADDR);
  localparam logic [PO_ADDR_WIDTH-1:0]      E_LAST = PO_ADDR_WIDTH'(PO_ENTRY_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH-1:0] T_LAST = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [PO_ENTRY_WIDTH-1:0]     PO_INIT = PO_ENTRY_WIDTH'(PO_INIT_VALUE);

  // A DO address inside the PO window would let one writeback raise both
  // write enables, so it is rejected when the block is elaborated.
  if ((DO_A >= PO_LO) && (DO_A <= PO_HI)) begin : g_do_in_po_range
    $error("address_offset_writer: DO_ADDR lies inside the PO address range");
  end
  if ((WORD_WIDTH < PO_ENTRY_WIDTH) || (WORD_WIDTH < ADDR_WIDTH)) begin : g_word_too_narrow
    $error("address_offset_writer: WORD_WIDTH narrower than PO entry or address");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t                        state_q, state_d;
  logic [PO_ADDR_WIDTH-1:0]      e_q, e_d;
  logic [THREAD_COUNT_WIDTH-1:0] t_q, t_d;

  logic                      po_hit_p0, do_hit_p0;
  logic [ADDR_WIDTH-1:0]     po_off_p0;
  logic                      po_wren_p0, do_wren_p0;
  logic [PO_ADDR_WIDTH-1:0]  po_addr_p0;
  logic [PO_ENTRY_WIDTH-1:0] po_data_p0;
  logic [ADDR_WIDTH-1:0]     do_data_p0;
  logic                      io_ready_p0, cancel_p0, busy_p0, dropped_p0;

  logic                      po_wren_p1, do_wren_p1;
  logic [PO_ADDR_WIDTH-1:0]  po_addr_p1;
  logic [PO_ENTRY_WIDTH-1:0] po_data_p1;
  logic [ADDR_WIDTH-1:0]     do_data_p1;
  logic                      io_ready_p1, cancel_p1, busy_p1, dropped_p1;

  // Upper writeback bits beyond the PO entry width are intentionally dropped.
  logic unused_write_data;
  assign unused_write_data = ^bus.write_data;

  // ---- p0: address decode and next-state / next-output selection ----
  assign po_hit_p0 = (bus.write_addr >= PO_LO) && (bus.write_addr <= PO_HI);
  assign do_hit_p0 = (bus.write_addr == DO_A);
  assign po_off_p0 = bus.write_addr - PO_LO;

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    t_d         = t_q;
    po_wren_p0  = 1'b0;
    do_wren_p0  = 1'b0;
    po_addr_p0  = po_addr_p1;
    po_data_p0  = po_data_p1;
    do_data_p0  = do_data_p1;
    io_ready_p0 = io_ready_p1;
    cancel_p0   = cancel_p1;
    busy_p0     = 1'b0;
    dropped_p0  = 1'b0;
    unique case (state_q)
      INIT: begin
        po_wren_p0  = 1'b1;
        po_addr_p0  = e_q;
        po_data_p0  = PO_INIT;
        io_ready_p0 = 1'b1;
        cancel_p0   = 1'b0;
        busy_p0     = 1'b1;
        dropped_p0  = bus.write_enable;
        if (t_q == T_LAST) begin
          t_d = '0;
          if (e_q == E_LAST) begin
            state_d = RUN;
          end else begin
            e_d = e_q + PO_ADDR_WIDTH'(1);
          end
        end else begin
          t_d = t_q + THREAD_COUNT_WIDTH'(1);
        end
      end
      RUN: begin
        po_wren_p0  = bus.write_enable & po_hit_p0;
        do_wren_p0  = bus.write_enable & do_hit_p0;
        io_ready_p0 = bus.IO_Ready_in;
        cancel_p0   = bus.Cancel_in;
        // Data outputs only move on an accepted write so a miss leaves the
        // last written value on the bus.
        if (po_wren_p0) begin
          po_addr_p0 = po_off_p0[PO_ADDR_WIDTH-1:0];
          po_data_p0 = bus.write_data[PO_ENTRY_WIDTH-1:0];
        end
        if (do_wren_p0) begin
          do_data_p0 = bus.write_data[ADDR_WIDTH-1:0];
        end
      end
    endcase
  end

  // ---- p1: state and registered outputs ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      e_q         <= '0;
      t_q         <= '0;
      po_wren_p1  <= 1'b0;
      do_wren_p1  <= 1'b0;
      po_addr_p1  <= '0;
      po_data_p1  <= '0;
      do_data_p1  <= '0;
      io_ready_p1 <= 1'b0;
      cancel_p1   <= 1'b0;
      busy_p1     <= 1'b1;
      dropped_p1  <= 1'b0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      t_q         <= t_d;
      po_wren_p1  <= po_wren_p0;
      do_wren_p1  <= do_wren_p0;
      po_addr_p1  <= po_addr_p0;
      po_data_p1  <= po_data_p0;
      do_data_p1  <= do_data_p0;
      io_ready_p1 <= io_ready_p0;
      cancel_p1   <= cancel_p0;
      busy_p1     <= busy_p0;
      dropped_p1  <= dropped_p0;
    end
  end

  assign bus.po_wren           = po_wren_p1;
  assign bus.po_write_addr     = po_addr_p1;
  assign bus.po_write_data     = po_data_p1;
  assign bus.do_wren           = do_wren_p1;
  assign bus.do_write_data     = do_data_p1;
  assign bus.IO_Ready_previous = io_ready_p1;
  assign bus.Cancel_previous   = cancel_p1;
  assign bus.init_busy         = busy_p1;
  assign bus.write_dropped     = dropped_p1;

endmodule

// File: tb/tb_address_offset_writer.sv
// tb_address_offset_writer
//   Directed bench for address_offset_writer with default parameters.
module tb_address_offset_writer;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  address_offset_writer_if bus ();

  address_offset_writer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_po_wren"},  64'(bus.po_wren), 64'd0);
    check({tag, "_do_wren"},  64'(bus.do_wren), 64'd0);
    check({tag, "_po_addr"},  64'(bus.po_write_addr), 64'd0);
    check({tag, "_po_data"},  64'(bus.po_write_data), 64'd0);
    check({tag, "_do_data"},  64'(bus.do_write_data), 64'd0);
    check({tag, "_io_prev"},  64'(bus.IO_Ready_previous), 64'd0);
    check({tag, "_can_prev"}, 64'(bus.Cancel_previous), 64'd0);
    check({tag, "_dropped"},  64'(bus.write_dropped), 64'd0);
    check({tag, "_busy"},     64'(bus.init_busy), 64'd1);
  endtask

  // Walks n init cycles (called on a negedge with reset just released).
  // Optionally raises write_enable so it is sampled on cycle 6.
  task automatic run_init(input int n, input bit inject_drop);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      check($sformatf("init%0d_po_wren", k), 64'(bus.po_wren), 64'd1);
      check($sformatf("init%0d_po_addr", k), 64'(bus.po_write_addr), 64'((k - 1) / 8));
      check($sformatf("init%0d_po_data", k), 64'(bus.po_write_data), 64'd0);
      check($sformatf("init%0d_do_wren", k), 64'(bus.do_wren), 64'd0);
      check($sformatf("init%0d_busy", k),    64'(bus.init_busy), 64'd1);
      check($sformatf("init%0d_io_prev", k), 64'(bus.IO_Ready_previous), 64'd1);
      check($sformatf("init%0d_can_prev", k), 64'(bus.Cancel_previous), 64'd0);
      check($sformatf("init%0d_dropped", k), 64'(bus.write_dropped),
            64'((inject_drop && k == 6) ? 1 : 0));
      if (inject_drop && k == 5) begin
        bus.write_enable = 1'b1;
        bus.write_addr   = 10'd1002;
        bus.write_data   = 36'h1_2345;
      end else begin
        bus.write_enable = 1'b0;
      end
    end
  endtask

  task automatic check_init_done(input string tag);
    @(negedge clock);
    check({tag, "_po_wren"}, 64'(bus.po_wren), 64'd0);
    check({tag, "_busy"},    64'(bus.init_busy), 64'd0);
    check({tag, "_dropped"}, 64'(bus.write_dropped), 64'd0);
  endtask

  // One RUN-mode writeback, checked on the following cycle.
  task automatic wb(input logic we, input logic [9:0] addr, input logic [35:0] data,
                    input logic io, input logic cancel);
    bus.write_enable = we;
    bus.write_addr   = addr;
    bus.write_data   = data;
    bus.IO_Ready_in  = io;
    bus.Cancel_in    = cancel;
    @(negedge clock);
    bus.write_enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n          = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.IO_Ready_in  = 1'b1;
    bus.Cancel_in    = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_values("rst");

    // Full init with a dropped writeback, then RUN.
    reset_n = 1'b1;
    run_init(32, 1'b1);
    check_init_done("init_end");

    wb(1'b1, 10'd1002, 36'h0_0001_2345, 1'b1, 1'b0);
    check("po1002_wren", 64'(bus.po_wren), 64'd1);
    check("po1002_addr", 64'(bus.po_write_addr), 64'd2);
    check("po1002_data", 64'(bus.po_write_data), 64'h1_2345);
    check("po1002_do_wren", 64'(bus.do_wren), 64'd0);

    wb(1'b1, 10'd1004, 36'h0_0000_03FF, 1'b1, 1'b0);
    check("do1004_wren", 64'(bus.do_wren), 64'd1);
    check("do1004_data", 64'(bus.do_write_data), 64'h3FF);
    check("do1004_po_wren", 64'(bus.po_wren), 64'd0);
    check("do1004_po_hold", 64'(bus.po_write_data), 64'h1_2345);

    wb(1'b1, 10'd999, 36'h0_0000_0055, 1'b1, 1'b0);
    check("a999_po_wren", 64'(bus.po_wren), 64'd0);
    check("a999_do_wren", 64'(bus.do_wren), 64'd0);
    check("a999_do_hold", 64'(bus.do_write_data), 64'h3FF);

    wb(1'b1, 10'd1003, 36'h0_000A_BCDE, 1'b1, 1'b0);
    check("a1003_po_wren", 64'(bus.po_wren), 64'd1);
    check("a1003_po_addr", 64'(bus.po_write_addr), 64'd3);
    check("a1003_po_data", 64'(bus.po_write_data), 64'hA_BCDE);

    wb(1'b1, 10'd1005, 36'h0_0000_0077, 1'b1, 1'b0);
    check("a1005_po_wren", 64'(bus.po_wren), 64'd0);
    check("a1005_do_wren", 64'(bus.do_wren), 64'd0);

    // Upper word bits are truncated to the 22-bit entry.
    wb(1'b1, 10'd1000, 36'hF_FFC0_0001, 1'b1, 1'b0);
    check("a1000_po_wren", 64'(bus.po_wren), 64'd1);
    check("a1000_po_addr", 64'(bus.po_write_addr), 64'd0);
    check("a1000_po_data", 64'(bus.po_write_data), 64'h00_0001);

    // Qualifiers forward without gating the write enable.
    wb(1'b1, 10'd1001, 36'h0_0000_0123, 1'b0, 1'b1);
    check("qual_po_wren", 64'(bus.po_wren), 64'd1);
    check("qual_po_addr", 64'(bus.po_write_addr), 64'd1);
    check("qual_io_prev", 64'(bus.IO_Ready_previous), 64'd0);
    check("qual_can_prev", 64'(bus.Cancel_previous), 64'd1);

    // write_enable low on a hit address: no write, data held.
    wb(1'b0, 10'd1004, 36'h0_0000_0111, 1'b1, 1'b0);
    check("we0_do_wren", 64'(bus.do_wren), 64'd0);
    check("we0_po_wren", 64'(bus.po_wren), 64'd0);
    check("we0_do_hold", 64'(bus.do_write_data), 64'h3FF);
    check("we0_po_hold", 64'(bus.po_write_addr), 64'd1);
    check("we0_io_prev", 64'(bus.IO_Ready_previous), 64'd1);
    check("run_busy", 64'(bus.init_busy), 64'd0);

    // Reset from RUN, then reset again at INIT cycle 20.
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_run");
    @(negedge clock);
    reset_n = 1'b1;
    run_init(20, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clock);
    check_reset_values("rst_mid_hold");
    reset_n = 1'b1;
    run_init(32, 1'b0);
    check_init_done("reinit_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
